// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pkg
// Brief   : Shared state encodings and constants for the instruction fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
    localparam int unsigned PC_STEP  = 4;

endpackage
`default_nettype wire

// File: rtl/ifu_hold_buf.sv
`default_nettype none
// ============================================================================
// Module  : ifu_hold_buf
// Brief   : Single-entry instruction/address buffer used while IF/ID is stalled.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_hold_buf #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] load_inst,
    input  logic [AW-1:0] load_addr,
    output logic [DW-1:0] buf_inst,
    output logic [AW-1:0] buf_addr,
    output logic          buf_valid
);

    logic [DW-1:0] r_inst;
    logic [AW-1:0] r_addr;
    logic          r_valid;

    // Load wins over clear so a same-cycle refill is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_inst  <= load_inst;
            r_addr  <= load_addr;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign buf_inst  = r_inst;
    assign buf_addr  = r_addr;
    assign buf_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch
// Brief   : Instruction fetch stage: PC, single-outstanding ibus fetch, IF/ID
//           register, redirect and stall handling. Optional performance
//           counters enabled by defining IFU_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          stall,
    output logic          ibus_req,
    output logic [AW-1:0] ibus_addr,
    input  logic          ibus_gnt,
    input  logic          ibus_rvalid,
    input  logic [DW-1:0] ibus_rdata,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_addr_o,
    output logic          inst_valid_o
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_drop_cnt
`endif
);

    localparam logic [DW-1:0] c_nop_inst = DW'(INST_NOP);
    localparam logic [AW-1:0] c_pc_step  = AW'(PC_STEP);
    localparam logic [AW-1:0] c_align    = ~AW'(3);

    ifu_state_e    r_state, w_state_next;
    logic [AW-1:0] r_pc, w_pc_next;
    logic [AW-1:0] r_req_pc, w_req_pc_next;
    logic          r_drop, w_drop_next;

    logic [DW-1:0] r_inst;
    logic [AW-1:0] r_inst_addr;
    logic          r_inst_valid;

    logic [AW-1:0] w_jump_target;
    logic          w_deliver_rsp;
    logic          w_deliver_buf;
    logic          w_drop_rsp;
    logic          w_drop_buf;
    logic          w_buf_load;
    logic          w_buf_clear;
    logic [DW-1:0] w_buf_inst;
    logic [AW-1:0] w_buf_addr;
    logic          w_buf_valid;

    assign w_jump_target = jump_addr & c_align;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req_pc <= w_req_pc_next;
            r_drop   <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_req_pc_next = r_req_pc;
        w_drop_next   = r_drop;
        w_deliver_rsp = 1'b0;
        w_deliver_buf = 1'b0;
        w_drop_rsp    = 1'b0;
        w_drop_buf    = 1'b0;
        w_buf_load    = 1'b0;
        w_buf_clear   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (jump_en) begin
                    w_pc_next = w_jump_target;
                end
            end

            S_REQ: begin
                if (ibus_gnt) begin
                    w_req_pc_next = r_pc;
                    w_pc_next     = r_pc + c_pc_step;
                    w_state_next  = S_WAIT;
                end
                // A fetch granted alongside a redirect is already stale.
                if (jump_en) begin
                    w_pc_next = w_jump_target;
                    if (ibus_gnt) begin
                        w_drop_next = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (jump_en) begin
                    w_pc_next = w_jump_target;
                    if (ibus_rvalid) begin
                        w_drop_rsp   = 1'b1;
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_drop_next  = 1'b1;
                    end
                end else if (ibus_rvalid) begin
                    if (r_drop) begin
                        w_drop_rsp   = 1'b1;
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else if (!stall) begin
                        w_deliver_rsp = 1'b1;
                        w_state_next  = S_REQ;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (jump_en) begin
                    w_pc_next    = w_jump_target;
                    w_drop_buf   = w_buf_valid;
                    w_buf_clear  = 1'b1;
                    w_state_next = S_REQ;
                end else if (!stall) begin
                    w_deliver_buf = w_buf_valid;
                    w_buf_clear   = 1'b1;
                    w_state_next  = S_REQ;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // IF/ID register: flush beats stall, stall holds, otherwise bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst       <= c_nop_inst;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
        end else if (jump_en) begin
            r_inst       <= c_nop_inst;
            r_inst_valid <= 1'b0;
        end else if (w_deliver_rsp) begin
            r_inst       <= ibus_rdata;
            r_inst_addr  <= r_req_pc;
            r_inst_valid <= 1'b1;
        end else if (w_deliver_buf) begin
            r_inst       <= w_buf_inst;
            r_inst_addr  <= w_buf_addr;
            r_inst_valid <= 1'b1;
        end else if (!stall) begin
            r_inst_valid <= 1'b0;
        end
    end

    ifu_hold_buf #(
        .AW (AW),
        .DW (DW)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (w_buf_load),
        .clear     (w_buf_clear),
        .load_inst (ibus_rdata),
        .load_addr (r_req_pc),
        .buf_inst  (w_buf_inst),
        .buf_addr  (w_buf_addr),
        .buf_valid (w_buf_valid)
    );

    assign ibus_req     = (r_state == S_REQ);
    assign ibus_addr    = r_pc;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_deliver_rsp || w_deliver_buf) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_drop_rsp || w_drop_buf) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_fetch
// Brief   : Self-checking bench for ifu_fetch: directed scenarios plus a
//           randomized bus/stall/redirect run against a program-order model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        stall;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ifu_fetch #(
        .AW       (32),
        .DW       (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .stall        (stall),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_gnt     (ibus_gnt),
        .ibus_rvalid  (ibus_rvalid),
        .ibus_rdata   (ibus_rdata),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Instruction memory contents as seen by the bench's bus slave.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; jump_en = 1'b0; jump_addr = '0; stall = 1'b0;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_en = 1'b0; jump_addr = '0; stall = 1'b0;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
        step();
        checks++;
        if ({ibus_req, inst_valid_o, inst_o, inst_addr_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            failures++;
            $display("FAIL reset_outputs: req=%b valid=%b inst=%h addr=%h want 0 0 %h 0",
                     ibus_req, inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({ibus_req, ibus_addr} !== {1'b1, RST_PC}) begin
            failures++;
            $display("FAIL reset_first_fetch: req=%b addr=%h want 1 %h", ibus_req, ibus_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        do_reset();
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ibus_req, ibus_addr} !== {1'b1, RST_PC + 32'(4 * k)}) begin
                failures++;
                $display("FAIL basic_req%0d: req=%b addr=%h want 1 %h", k, ibus_req, ibus_addr,
                         RST_PC + 32'(4 * k));
            end
            if (k > 0) begin
                checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !==
                    {1'b1, RST_PC + 32'(4 * (k - 1)), memf(RST_PC + 32'(4 * (k - 1)))}) begin
                    failures++;
                    $display("FAIL basic_out%0d: valid=%b addr=%h inst=%h want 1 %h %h", k,
                             inst_valid_o, inst_addr_o, inst_o, RST_PC + 32'(4 * (k - 1)),
                             memf(RST_PC + 32'(4 * (k - 1))));
                end
            end
            ibus_gnt = 1'b1;
            step();
            ibus_gnt = 1'b0;
            checks++;
            if ({ibus_req, inst_valid_o} !== 2'b00) begin
                failures++;
                $display("FAIL basic_wait%0d: req=%b valid=%b want 0 0", k, ibus_req, inst_valid_o);
            end
            ibus_rvalid = 1'b1;
            ibus_rdata  = memf(RST_PC + 32'(4 * k));
            step();
            ibus_rvalid = 1'b0;
        end
        checks++;
        if ({inst_valid_o, inst_addr_o} !== {1'b1, RST_PC + 32'h8}) begin
            failures++;
            $display("FAIL basic_last: valid=%b addr=%h want 1 %h", inst_valid_o, inst_addr_o, RST_PC + 32'h8);
        end
    endtask

    task automatic test_gnt_delay();
        do_reset();
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ibus_req, ibus_addr, inst_valid_o} !== {1'b1, RST_PC, 1'b0}) begin
                failures++;
                $display("FAIL gnt_delay_hold%0d: req=%b addr=%h valid=%b want 1 %h 0", k,
                         ibus_req, ibus_addr, inst_valid_o, RST_PC);
            end
            step();
        end
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1;
        ibus_rdata  = memf(RST_PC);
        step();
        ibus_rvalid = 1'b0;
        checks++;
        if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, RST_PC, memf(RST_PC)}) begin
            failures++;
            $display("FAIL gnt_delay_out: valid=%b addr=%h inst=%h want 1 %h %h",
                     inst_valid_o, inst_addr_o, inst_o, RST_PC, memf(RST_PC));
        end
    endtask

    task automatic test_jump();
        do_reset();
        step();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = memf(RST_PC);
        jump_en = 1'b1; jump_addr = 32'h200;
        step();
        ibus_rvalid = 1'b0; jump_en = 1'b0;
        checks++;
        if ({inst_valid_o, inst_o, ibus_req, ibus_addr} !== {1'b0, NOP, 1'b1, 32'h200}) begin
            failures++;
            $display("FAIL jump_rvalid: valid=%b inst=%h req=%b addr=%h want 0 %h 1 200",
                     inst_valid_o, inst_o, ibus_req, ibus_addr, NOP);
        end
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = memf(32'h200);
        step();
        ibus_rvalid = 1'b0;
        checks++;
        if ({inst_valid_o, inst_addr_o, ibus_addr} !== {1'b1, 32'h200, 32'h204}) begin
            failures++;
            $display("FAIL jump_target_fetch: valid=%b addr=%h next=%h want 1 200 204",
                     inst_valid_o, inst_addr_o, ibus_addr);
        end
        jump_en = 1'b1; jump_addr = 32'h203;
        step();
        jump_en = 1'b0;
        checks++;
        if ({ibus_req, ibus_addr, inst_valid_o} !== {1'b1, 32'h200, 1'b0}) begin
            failures++;
            $display("FAIL jump_align: req=%b addr=%h valid=%b want 1 200 0", ibus_req, ibus_addr, inst_valid_o);
        end
        jump_en = 1'b1; jump_addr = 32'h300; ibus_gnt = 1'b1;
        step();
        jump_en = 1'b0; ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = memf(32'h200);
        step();
        ibus_rvalid = 1'b0;
        checks++;
        if ({inst_valid_o, ibus_req, ibus_addr} !== {1'b0, 1'b1, 32'h300}) begin
            failures++;
            $display("FAIL jump_with_gnt: valid=%b req=%b addr=%h want 0 1 300", inst_valid_o, ibus_req, ibus_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        stall = 1'b1; ibus_rvalid = 1'b1; ibus_rdata = memf(RST_PC);
        step();
        ibus_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ibus_req, inst_valid_o, inst_o} !== {1'b0, 1'b0, NOP}) begin
                failures++;
                $display("FAIL stall_hold%0d: req=%b valid=%b inst=%h want 0 0 %h", k, ibus_req, inst_valid_o, inst_o, NOP);
            end
            step();
        end
        stall = 1'b0;
        step();
        checks++;
        if ({inst_valid_o, inst_addr_o, inst_o, ibus_req, ibus_addr} !==
            {1'b1, RST_PC, memf(RST_PC), 1'b1, RST_PC + 32'h4}) begin
            failures++;
            $display("FAIL stall_release: valid=%b addr=%h inst=%h req=%b next=%h want 1 %h %h 1 %h",
                     inst_valid_o, inst_addr_o, inst_o, ibus_req, ibus_addr, RST_PC, memf(RST_PC), RST_PC + 32'h4);
        end
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = memf(RST_PC + 32'h4);
        step();
        ibus_rvalid = 1'b0;
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        checks++;
        if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, RST_PC + 32'h4, memf(RST_PC + 32'h4)}) begin
            failures++;
            $display("FAIL stall_output_hold: valid=%b addr=%h inst=%h want 1 %h %h",
                     inst_valid_o, inst_addr_o, inst_o, RST_PC + 32'h4, memf(RST_PC + 32'h4));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        checks++;
        if (ibus_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_jump: addr=%h want fffffffc", ibus_addr);
        end
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = memf(32'hFFFF_FFFC);
        step();
        ibus_rvalid = 1'b0;
        checks++;
        if ({inst_valid_o, inst_addr_o, ibus_req, ibus_addr} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wrap_next: valid=%b addr=%h req=%b next=%h want 1 fffffffc 1 0",
                     inst_valid_o, inst_addr_o, ibus_req, ibus_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        rst = 1'b1; ibus_rvalid = 1'b1; ibus_rdata = memf(RST_PC);
        #1;
        checks++;
        if ({ibus_req, inst_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_async: req=%b valid=%b want 0 0", ibus_req, inst_valid_o);
        end
        step();
        rst = 1'b0;
        step();
        ibus_rvalid = 1'b0;
        checks++;
        if ({inst_valid_o, ibus_req, ibus_addr} !== {1'b0, 1'b1, RST_PC}) begin
            failures++;
            $display("FAIL reset_mid_late_rvalid: valid=%b req=%b addr=%h want 0 1 %h",
                     inst_valid_o, ibus_req, ibus_addr, RST_PC);
        end
`ifdef IFU_PERF_EN
        checks++;
        if ({perf_fetch_cnt, perf_drop_cnt} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid_perf: fetch=%0d drop=%0d want 0 0", perf_fetch_cnt, perf_drop_cnt);
        end
`endif
    endtask

    // Randomized run: bus slave with 1..3 cycle latency and a program-order model.
    logic        sl_out;
    logic [31:0] sl_addr;
    int          sl_delay;
    logic [31:0] exp_addr;
    int          n_deliv;
    int          n_rsp;

    task automatic rand_cycle(input bit allow);
        logic        hs, rsp, p_jump, p_stall;
        logic [31:0] hs_addr, p_target;
        logic [64:0] prev_out;
        if (sl_out && sl_delay == 0) begin
            ibus_rvalid = 1'b1; ibus_rdata = memf(sl_addr);
        end else begin
            ibus_rvalid = !sl_out && ($urandom % 5 == 0);
            ibus_rdata  = $urandom;
        end
        ibus_gnt  = allow ? ($urandom % 3 != 0) : 1'b0;
        stall     = allow ? ($urandom % 4 == 0) : 1'b0;
        jump_en   = allow ? ($urandom % 12 == 0) : 1'b0;
        jump_addr = 32'h400 + ($urandom & 32'hFF);
        if (sl_out) begin
            checks++;
            if (ibus_req !== 1'b0) begin
                failures++;
                $display("FAIL rand_outstanding: req=%b with fetch outstanding, want 0", ibus_req);
            end
        end
        hs       = ibus_req && ibus_gnt;
        hs_addr  = ibus_addr;
        rsp      = sl_out && sl_delay == 0;
        p_jump   = jump_en;
        p_stall  = stall;
        p_target = jump_addr & ~32'h3;
        prev_out = {inst_valid_o, inst_o, inst_addr_o};
        step();
        if (rsp) begin
            sl_out = 1'b0;
            n_rsp++;
        end else if (sl_out) begin
            sl_delay--;
        end
        if (hs) begin
            sl_out = 1'b1; sl_addr = hs_addr; sl_delay = int'($urandom % 3);
        end
        if (p_jump) begin
            exp_addr = p_target;
            checks++;
            if ({inst_valid_o, inst_o} !== {1'b0, NOP}) begin
                failures++;
                $display("FAIL rand_flush: valid=%b inst=%h want 0 %h", inst_valid_o, inst_o, NOP);
            end
        end else if (p_stall) begin
            checks++;
            if ({inst_valid_o, inst_o, inst_addr_o} !== prev_out) begin
                failures++;
                $display("FAIL rand_stall_hold: out=%h want %h", {inst_valid_o, inst_o, inst_addr_o}, prev_out);
            end
        end else if (inst_valid_o) begin
            n_deliv++;
            checks++;
            if ({inst_addr_o, inst_o} !== {exp_addr, memf(exp_addr)}) begin
                failures++;
                $display("FAIL rand_stream: addr=%h inst=%h want %h %h", inst_addr_o, inst_o, exp_addr, memf(exp_addr));
            end
            exp_addr = exp_addr + 32'h4;
        end
    endtask

    task automatic test_random();
        do_reset();
        sl_out = 1'b0; sl_addr = '0; sl_delay = 0;
        exp_addr = RST_PC; n_deliv = 0; n_rsp = 0;
        for (int i = 0; i < 600; i++) rand_cycle(1'b1);
        for (int i = 0; i < 8; i++) rand_cycle(1'b0);
        checks++;
        if (n_deliv < 20) begin
            failures++;
            $display("FAIL rand_progress: delivered=%0d want >=20", n_deliv);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'(n_deliv)) begin
            failures++;
            $display("FAIL rand_perf_fetch: got %0d want %0d", perf_fetch_cnt, n_deliv);
        end
        checks++;
        if (perf_fetch_cnt + perf_drop_cnt !== 32'(n_rsp)) begin
            failures++;
            $display("FAIL rand_perf_total: fetch+drop=%0d want %0d", perf_fetch_cnt + perf_drop_cnt, n_rsp);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_delay();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
